// File: rtl/pipe_start.sv
// Entry stage of the Kyber NTT/INTT butterfly pipeline: buffers the first half of each
// butterfly group and emits (lower, upper) coefficient pairs with their twiddle address.
module pipe_start (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] o1,
  output logic [11:0] o2,
  output logic [6:0]  w_raddr,
  output logic        poly_done
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both high;
  // valid never waits on ready, and o1/o2/w_raddr/poly_done stay frozen while
  // out_valid=1 and out_ready=0.

  logic [7:0]  idx;
  logic        mode_q;
  logic        eff_mode;
  logic        fill;
  logic        accept;
  logic [6:0]  buf_addr;
  logic [5:0]  group;
  logic [11:0] mem [128];

  // The first beat of a polynomial is steered by the live mode because mode_q only
  // captures it on that same edge.
  assign eff_mode = (idx == 8'd0) ? mode : mode_q;

  // NTT distance 128: fill while idx<128. INTT distance 2: fill on idx%4 in {0,1}.
  assign fill     = eff_mode ? ~idx[1] : ~idx[7];
  assign buf_addr = eff_mode ? {6'd0, idx[0]} : idx[6:0];
  assign group    = idx[7:2];

  assign in_ready = fill | out_ready | ~out_valid;
  assign accept   = in_valid & in_ready;

  // Fill writes and pair reads share one address: p during fill, p-D during pairing.
  always_ff @(posedge clk) begin
    if (accept && fill) begin
      mem[buf_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= 8'd0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      o1        <= 12'd0;
      o2        <= 12'd0;
      w_raddr   <= 7'd0;
      poly_done <= 1'b0;
    end else begin
      if (accept) begin
        idx <= idx + 8'd1;
        if (idx == 8'd0) begin
          mode_q <= mode;
        end
      end
      if (accept && !fill) begin
        o1        <= mem[buf_addr];
        o2        <= in_data;
        out_valid <= 1'b1;
        w_raddr   <= eff_mode ? (7'd127 - {1'b0, group}) : 7'd1;
        poly_done <= (idx == 8'd255);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        poly_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_start.sv
// Randomized and directed bench for pipe_start: a pair-list model per polynomial feeds
// an expected queue that a negedge monitor drains against the DUT output stream.
module tb_pipe_start;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] o1;
  logic [11:0] o2;
  logic [6:0]  w_raddr;
  logic        poly_done;

  pipe_start dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o1        (o1),
    .o2        (o2),
    .w_raddr   (w_raddr),
    .poly_done (poly_done)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          done_exp = 0;
  int          done_seen = 0;
  bit          rand_ready = 1'b0;
  bit          rand_gaps = 1'b0;
  bit          lat_arm = 1'b0;
  int          acc_cyc = -1;
  int          out_cyc = -1;
  logic [11:0] coef [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  function automatic logic [31:0] pack(input logic [11:0] a, input logic [11:0] b,
                                       input logic [6:0] w, input logic d);
    return {a, b, w, d};
  endfunction

  // Reference: the full list of butterfly pairs a polynomial must produce, in order.
  function automatic void model_poly(input bit m);
    if (!m) begin
      for (int j = 0; j < 128; j++)
        exp_q.push_back(pack(coef[j], coef[j + 128], 7'd1, j == 127));
    end else begin
      for (int g = 0; g < 64; g++)
        for (int k = 0; k < 2; k++)
          exp_q.push_back(pack(coef[4*g + k], coef[4*g + k + 2], 7'(127 - g),
                               (g == 63) && (k == 1)));
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (lat_arm) begin
        if (in_valid && in_ready && acc_cyc < 0) acc_cyc = cyc;
        if (out_valid && out_cyc < 0) out_cyc = cyc;
      end
      check("done_without_valid", {31'd0, poly_done & ~out_valid}, 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pair", {20'd0, o1}, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = out_ready ? exp_q.pop_front() : exp_q[0];
          check("o1", {20'd0, o1}, {20'd0, e[31:20]});
          check("o2", {20'd0, o2}, {20'd0, e[19:8]});
          check("w_raddr", {25'd0, w_raddr}, {25'd0, e[7:1]});
          check("poly_done", {31'd0, poly_done}, {31'd0, e[0]});
        end
        if (out_ready && poly_done) done_seen++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [11:0] data, input bit m, input bit exp_fill);
    bit ok;
    int tries;
    ok = 1'b0;
    tries = 0;
    in_valid = 1'b1;
    in_data = data;
    mode = m;
    while (!ok) begin
      @(negedge clk);
      if (exp_fill) check("fill_in_ready", {31'd0, in_ready}, 32'd1);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      tries++;
      if (!ok && tries > 200) begin
        check("accept_timeout", 32'(tries), 32'd0);
        ok = 1'b1;
      end
    end
  endtask

  task automatic do_reset_mid();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_poly_done", {31'd0, poly_done}, 32'd0);
    check("rst_w_raddr", {25'd0, w_raddr}, 32'd0);
    check("rst_o1", {20'd0, o1}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send_poly(input bit m, input int stall_j, input int toggle_at,
                           input int reset_at);
    model_poly(m);
    for (int i = 0; i < 256; i++) begin
      bit fill_pos;
      if (i == reset_at) begin
        do_reset_mid();
        return;
      end
      if (rand_gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      fill_pos = m ? ((i % 4) < 2) : (i < 128);
      if (!m && stall_j >= 0 && i == 129 + stall_j) begin
        in_valid = 1'b1;
        in_data = coef[i];
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          check("stall_o1", {20'd0, o1}, {20'd0, coef[stall_j]});
          check("stall_o2", {20'd0, o2}, {20'd0, coef[stall_j + 128]});
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      send_beat(coef[i], (toggle_at >= 0 && i >= toggle_at) ? ~m : m, fill_pos);
    end
    in_valid = 1'b0;
    done_exp++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_coef(input int offset);
    for (int i = 0; i < 256; i++) coef[i] = 12'(i + offset);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst = 1'b0;
    mode = 1'b0;
    in_valid = 1'b0;
    in_data = 12'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_o1", {20'd0, o1}, 32'd0);
    check("reset_o2", {20'd0, o2}, 32'd0);
    check("reset_w_raddr", {25'd0, w_raddr}, 32'd0);
    check("reset_poly_done", {31'd0, poly_done}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // NTT streaming with first-output latency measurement
    fill_coef(0);
    lat_arm = 1'b1;
    send_poly(1'b0, -1, -1, -1);
    drain();
    lat_arm = 1'b0;
    check("first_pair_latency", 32'(out_cyc - acc_cyc), 32'd129);

    // INTT streaming
    send_poly(1'b1, -1, -1, -1);
    drain();

    // NTT with backpressure at pair 10
    send_poly(1'b0, 10, -1, -1);
    drain();

    // Mode toggled mid-polynomial, then an INTT polynomial
    send_poly(1'b0, -1, 50, -1);
    send_poly(1'b1, -1, -1, -1);
    drain();

    // Asynchronous reset mid-stream, then clean restart
    send_poly(1'b0, -1, -1, 200);
    send_poly(1'b0, -1, -1, -1);
    drain();

    // Back-to-back NTT polynomials
    d0 = done_seen;
    send_poly(1'b0, -1, -1, -1);
    fill_coef(1000);
    send_poly(1'b0, -1, -1, -1);
    drain();
    check("b2b_done_pulses", 32'(done_seen - d0), 32'd2);

    // Randomized data, mode, gaps, backpressure and ignored mode changes
    rand_ready = 1'b1;
    rand_gaps = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) coef[i] = 12'($urandom_range(0, 4095));
      send_poly(1'($urandom_range(0, 1)), -1, (p % 2 == 0) ? int'($urandom_range(1, 255)) : -1, -1);
    end
    rand_ready = 1'b0;
    rand_gaps = 1'b0;
    drain();

    check("poly_done_total", 32'(done_seen), 32'(done_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
